// File: rtl/enigma_feeder.sv
// enigma_feeder: turns one valid/ready byte stream into the Enigma encryptor's
// level-sensitive control inputs. The first TABLE_ENTRIES accepted bytes load
// the rotor table; every later byte is a text code issued for one encrypt cycle.
// Priming and flush cycles hide the encryptor's IDLE->LOAD and LOAD->READY
// state-entry latencies from the upstream producer.
module enigma_feeder #(
    parameter int TABLE_ENTRIES = 192
) (
    input  logic        clk,
    input  logic        srstn,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_mode,
    output logic        in_ready,
    output logic        load,
    output logic [7:0]  load_idx,
    output logic [5:0]  code_in,
    output logic        encrypt,
    output logic        crypt_mode,
    output logic        table_done,
    output logic [15:0] char_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    // Index of the final table entry; 9 bits so a 256-entry table fits.
    localparam logic [8:0] LAST_IDX = 9'(TABLE_ENTRIES - 1);

    state_t      state_r;
    logic [8:0]  cnt_r;
    logic        load_r;
    logic [7:0]  load_idx_r;
    logic [5:0]  code_in_r;
    logic        encrypt_r;
    logic        crypt_mode_r;
    logic        table_done_r;
    logic [15:0] char_cnt_r;
    logic        in_ready_s;
    logic        xfer_s;

    // Accept bytes only while table entries remain, and for the whole text phase.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (cnt_r <= LAST_IDX) begin
                    in_ready_s = 1'b1;
                end else begin
                    in_ready_s = 1'b0;
                end
            end
            ST_RUN:  in_ready_s = 1'b1;
            default: in_ready_s = 1'b0;
        endcase
        xfer_s = in_valid & in_ready_s;
    end

    // Sequencer and registered encryptor controls; outputs only change on a
    // transfer or a state step, so a stalled LOAD simply re-presents the last entry.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 9'd0;
            load_r       <= 1'b0;
            load_idx_r   <= 8'd0;
            code_in_r    <= 6'd0;
            encrypt_r    <= 1'b0;
            crypt_mode_r <= 1'b0;
            table_done_r <= 1'b0;
            char_cnt_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_PRIME;
                        cnt_r      <= 9'd0;
                        load_r     <= 1'b1;
                        load_idx_r <= 8'd0;
                        code_in_r  <= 6'd0;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        load_idx_r <= cnt_r[7:0];
                        code_in_r  <= in_data[5:0];
                        cnt_r      <= cnt_r + 9'd1;
                        if (cnt_r == LAST_IDX) begin
                            state_r <= ST_FLUSH;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_FLUSH: begin
                    state_r      <= ST_RUN;
                    load_r       <= 1'b0;
                    table_done_r <= 1'b1;
                end
                ST_RUN: begin
                    encrypt_r <= xfer_s;
                    if (xfer_s) begin
                        code_in_r    <= in_data[5:0];
                        crypt_mode_r <= in_mode;
                        char_cnt_r   <= char_cnt_r + 16'd1;
                    end else begin
                        char_cnt_r   <= char_cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign load       = load_r;
    assign load_idx   = load_idx_r;
    assign code_in    = code_in_r;
    assign encrypt    = encrypt_r;
    assign crypt_mode = crypt_mode_r;
    assign table_done = table_done_r;
    assign char_cnt   = char_cnt_r;

endmodule

// File: tb/tb_enigma_feeder.sv
// Bench for enigma_feeder: directed load/text scenarios plus random traffic,
// compared every cycle against a timeline model built from the feeder's rules.
module tb_enigma_feeder;

    localparam int N = 192;

    logic        clk;
    logic        srstn;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_mode;
    logic        in_ready;
    logic        load;
    logic [7:0]  load_idx;
    logic [5:0]  code_in;
    logic        encrypt;
    logic        crypt_mode;
    logic        table_done;
    logic [15:0] char_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycle number since start, entries accepted, cycle of
    // the last entry transfer, and the most recently issued values.
    bit m_active;
    int m_c;
    int m_n;
    int m_last;
    int m_idx;
    int m_code;
    bit m_enc;
    bit m_mode;
    int m_cnt;

    enigma_feeder #(.TABLE_ENTRIES(N)) dut (
        .clk(clk), .srstn(srstn), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_mode(in_mode), .in_ready(in_ready),
        .load(load), .load_idx(load_idx), .code_in(code_in),
        .encrypt(encrypt), .crypt_mode(crypt_mode),
        .table_done(table_done), .char_cnt(char_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0; m_c = 0; m_n = 0; m_last = -1;
        m_idx = 0; m_code = 0; m_enc = 1'b0; m_mode = 1'b0; m_cnt = 0;
    endtask

    function automatic bit exp_ready();
        if (!m_active) return 1'b0;
        if (m_c >= 2 && m_n < N) return 1'b1;
        if (m_last >= 0 && m_c >= m_last + 2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_load();
        return m_active && (m_last < 0 || m_c <= m_last + 1);
    endfunction

    function automatic bit exp_done();
        return m_active && m_last >= 0 && m_c >= m_last + 2;
    endfunction

    function automatic logic [7:0] entry_byte(input int k);
        logic [1:0] junk;
        junk = 2'($urandom);
        return {junk, 6'((k * 5) & 63)};
    endfunction

    // One clock cycle: drive, check in_ready before the edge, advance the model,
    // then check every registered output just after the edge.
    task automatic step(input bit s, input bit v, input logic [7:0] d, input bit m);
        bit r;
        bit x;
        start = s; in_valid = v; in_data = d; in_mode = m;
        #2;
        r = exp_ready();
        if (srstn) chk("in_ready", 32'(in_ready), 32'(r));
        x = v && r;
        @(posedge clk);
        if (!srstn) begin
            model_clear();
        end else if (!m_active) begin
            if (s) begin
                m_active = 1'b1; m_c = 1; m_idx = 0; m_code = 0;
            end
        end else begin
            m_enc = 1'b0;
            if (x && m_last < 0) begin
                m_idx = m_n; m_code = int'(d & 8'h3F); m_n++;
                if (m_n == N) m_last = m_c;
            end else if (x) begin
                m_enc = 1'b1; m_code = int'(d & 8'h3F); m_mode = m;
                m_cnt = (m_cnt + 1) % 65536;
            end
            m_c++;
        end
        #1;
        chk("load", 32'(load), 32'(exp_load()));
        chk("load_idx", 32'(load_idx), 32'(m_idx));
        chk("code_in", 32'(code_in), 32'(m_code));
        chk("encrypt", 32'(encrypt), 32'(m_enc));
        chk("crypt_mode", 32'(crypt_mode), 32'(m_mode));
        chk("table_done", 32'(table_done), 32'(exp_done()));
        chk("char_cnt", 32'(char_cnt), 32'(m_cnt));
    endtask

    logic [7:0] text_d [3];
    bit         text_m [3];

    initial begin
        int stall;
        text_d[0] = 8'h05; text_d[1] = 8'h3F; text_d[2] = 8'hC1;
        text_m[0] = 1'b0;  text_m[1] = 1'b1;  text_m[2] = 1'b0;
        model_clear();

        // Reset for two cycles, then idle with in_valid high and no start.
        srstn = 1'b0;
        step(1'b0, 1'b1, 8'($urandom), 1'b0);
        step(1'b1, 1'b1, 8'($urandom), 1'b1);
        srstn = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'($urandom), 1'($urandom));

        // First load: stall three cycles after entry 10, reset at entry 50.
        step(1'b1, 1'b1, entry_byte(0), 1'b0);
        stall = 0;
        for (int i = 0; i < 200 && m_n < 50; i++) begin
            if (m_n == 11 && stall < 3) begin
                stall++;
                step(1'b0, 1'b0, 8'($urandom), 1'b0);
            end else begin
                step(1'($urandom), 1'b1, entry_byte(m_n), 1'b0);
            end
        end
        chk("entries_before_reset", 32'(m_n), 32'd50);
        srstn = 1'b0;
        step(1'b0, 1'b1, 8'($urandom), 1'b0);
        srstn = 1'b1;
        step(1'b0, 1'b0, 8'($urandom), 1'b0);

        // Full load without stalls, valid held through FLUSH into the text bytes.
        step(1'b1, 1'b1, entry_byte(0), 1'b0);
        for (int i = 0; i < 400 && m_cnt < 3; i++) begin
            if (m_last < 0) step(1'b0, 1'b1, entry_byte(m_n), 1'b0);
            else            step(1'b0, 1'b1, text_d[m_cnt], text_m[m_cnt]);
        end
        step(1'b0, 1'b0, 8'($urandom), 1'b1);
        step(1'b0, 1'b0, 8'($urandom), 1'b1);
        chk("char_cnt_after_text", 32'(char_cnt), 32'd3);
        chk("code_in_after_text", 32'(code_in), 32'd1);

        // Random text traffic with stray start pulses.
        for (int i = 0; i < 300; i++)
            step(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));

        // Reset out of RUN, then a short random-valid reload.
        srstn = 1'b0;
        step(1'b0, 1'b1, 8'($urandom), 1'b0);
        srstn = 1'b1;
        step(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 60; i++) step(1'($urandom), 1'($urandom), entry_byte(m_n), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
